// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 VGA timing constants and coordinate types.
// Used by vga_sync_gen and by the character generator for display bounds.
package vga_timing_pkg;

  localparam int unsigned COORD_W = 10;

  localparam int unsigned DEF_CLK_DIV   = 4;
  localparam int unsigned DEF_H_DISPLAY = 640;
  localparam int unsigned DEF_H_FP      = 16;
  localparam int unsigned DEF_H_SYNC    = 96;
  localparam int unsigned DEF_H_BP      = 48;
  localparam int unsigned DEF_V_DISPLAY = 480;
  localparam int unsigned DEF_V_FP      = 10;
  localparam int unsigned DEF_V_SYNC    = 2;
  localparam int unsigned DEF_V_BP      = 33;

  localparam int unsigned DEF_H_TOTAL = DEF_H_DISPLAY + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int unsigned DEF_V_TOTAL = DEF_V_DISPLAY + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  localparam int unsigned DEF_H_SYNC_START = DEF_H_DISPLAY + DEF_H_FP;
  localparam int unsigned DEF_H_SYNC_END   = DEF_H_SYNC_START + DEF_H_SYNC - 1;
  localparam int unsigned DEF_V_SYNC_START = DEF_V_DISPLAY + DEF_V_FP;
  localparam int unsigned DEF_V_SYNC_END   = DEF_V_SYNC_START + DEF_V_SYNC - 1;

  typedef logic [COORD_W-1:0] coord_t;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic video_on;
  } sync_t;

endpackage

// File: rtl/pixel_tick_gen.sv
// Divides clk by CLK_DIV; tick_c is the combinational wrap strobe and
// p_tick_o its registered one-clk pulse.
module pixel_tick_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic reset,
  output logic tick_c,
  output logic p_tick_o
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             p_tick_q;

  always_comb begin
    tick_c    = (div_cnt_q == DIV_W'(CLK_DIV - 1));
    div_cnt_d = tick_c ? '0 : div_cnt_q + DIV_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_q <= '0;
      p_tick_q  <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      p_tick_q  <= tick_c;
    end
  end

  assign p_tick_o = p_tick_q;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA scan counters and sync/blank decode driven by pixel_tick_gen.
// Optional VGA_FRAME_TICK_EN adds a frame_tick pulse on the (0,0) wrap.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV   = DEF_CLK_DIV,
  parameter int unsigned H_DISPLAY = DEF_H_DISPLAY,
  parameter int unsigned H_FP      = DEF_H_FP,
  parameter int unsigned H_SYNC    = DEF_H_SYNC,
  parameter int unsigned H_BP      = DEF_H_BP,
  parameter int unsigned V_DISPLAY = DEF_V_DISPLAY,
  parameter int unsigned V_FP      = DEF_V_FP,
  parameter int unsigned V_SYNC    = DEF_V_SYNC,
  parameter int unsigned V_BP      = DEF_V_BP
) (
  input  logic               clk,
  input  logic               reset,
  output logic               p_tick,
  output logic [COORD_W-1:0] pixel_x,
  output logic [COORD_W-1:0] pixel_y,
  output logic               hsync,
  output logic               vsync,
  output logic               video_on
`ifdef VGA_FRAME_TICK_EN
  ,
  output logic               frame_tick
`endif
);

  localparam int unsigned H_TOTAL = H_DISPLAY + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_DISPLAY + V_FP + V_SYNC + V_BP;

  localparam coord_t H_MAX    = COORD_W'(H_TOTAL - 1);
  localparam coord_t V_MAX    = COORD_W'(V_TOTAL - 1);
  localparam coord_t H_VIS    = COORD_W'(H_DISPLAY);
  localparam coord_t V_VIS    = COORD_W'(V_DISPLAY);
  localparam coord_t HS_START = COORD_W'(H_DISPLAY + H_FP);
  localparam coord_t HS_END   = COORD_W'(H_DISPLAY + H_FP + H_SYNC - 1);
  localparam coord_t VS_START = COORD_W'(V_DISPLAY + V_FP);
  localparam coord_t VS_END   = COORD_W'(V_DISPLAY + V_FP + V_SYNC - 1);

  logic   tick;
  logic   h_end, v_end;
  coord_t x_q, x_d, y_q, y_d;
  sync_t  sync_q, sync_d;

  pixel_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk      (clk),
    .reset    (reset),
    .tick_c   (tick),
    .p_tick_o (p_tick)
  );

  // Decode from next-state counters so sync lines up with pixel_x/pixel_y.
  always_comb begin
    h_end = (x_q == H_MAX);
    v_end = (y_q == V_MAX);
    x_d   = x_q;
    y_d   = y_q;
    if (tick) begin
      x_d = h_end ? '0 : x_q + COORD_W'(1);
      if (h_end) begin
        y_d = v_end ? '0 : y_q + COORD_W'(1);
      end
    end
    sync_d.hsync    = !((x_d >= HS_START) && (x_d <= HS_END));
    sync_d.vsync    = !((y_d >= VS_START) && (y_d <= VS_END));
    sync_d.video_on = (x_d < H_VIS) && (y_d < V_VIS);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q    <= '0;
      y_q    <= '0;
      sync_q <= '{hsync: 1'b1, vsync: 1'b1, video_on: 1'b1};
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      sync_q <= sync_d;
    end
  end

  assign pixel_x  = x_q;
  assign pixel_y  = y_q;
  assign hsync    = sync_q.hsync;
  assign vsync    = sync_q.vsync;
  assign video_on = sync_q.video_on;

`ifdef VGA_FRAME_TICK_EN
  logic frame_tick_q, frame_tick_d;

  always_comb begin
    frame_tick_d = tick && h_end && v_end;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_tick_q <= 1'b0;
    end else begin
      frame_tick_q <= frame_tick_d;
    end
  end

  assign frame_tick = frame_tick_q;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a full-size instance and a shrunk-timing instance,
// each checked every cycle against an arithmetic model of the scan position.
module tb_vga_sync_gen;

  logic       clk = 1'b0;
  logic       rst   [2];
  logic       p     [2];
  logic [9:0] px    [2];
  logic [9:0] py    [2];
  logic       hs    [2];
  logic       vs    [2];
  logic       von   [2];
  logic       ft    [2];
  logic       done  [2];

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  vga_sync_gen dut_f (
    .clk(clk), .reset(rst[0]), .p_tick(p[0]), .pixel_x(px[0]), .pixel_y(py[0]),
    .hsync(hs[0]), .vsync(vs[0]), .video_on(von[0])
`ifdef VGA_FRAME_TICK_EN
    , .frame_tick(ft[0])
`endif
  );

  vga_sync_gen #(
    .CLK_DIV(2), .H_DISPLAY(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_DISPLAY(10), .V_FP(2), .V_SYNC(2), .V_BP(3)
  ) dut_s (
    .clk(clk), .reset(rst[1]), .p_tick(p[1]), .pixel_x(px[1]), .pixel_y(py[1]),
    .hsync(hs[1]), .vsync(vs[1]), .video_on(von[1])
`ifdef VGA_FRAME_TICK_EN
    , .frame_tick(ft[1])
`endif
  );

`ifndef VGA_FRAME_TICK_EN
  initial begin
    ft[0] = 1'b0;
    ft[1] = 1'b0;
  end
`endif

  typedef struct packed {
    int unsigned div, hd, hfp, hs, hbp, vd, vfp, vs, vbp;
  } cfg_t;

  typedef struct packed {
    logic       p;
    logic [9:0] x;
    logic [9:0] y;
    logic       hs, vs, von, ft;
  } exp_t;

  function automatic cfg_t cfg(input int idx);
    if (idx == 0) return '{4, 640, 16, 96, 48, 480, 10, 2, 33};
    return '{2, 16, 2, 4, 3, 10, 2, 2, 3};
  endfunction

  // e = clk edges since the last reset edge; one pixel per div edges.
  function automatic exp_t model(input int idx, input int unsigned e);
    cfg_t        c = cfg(idx);
    exp_t        m;
    int unsigned ht, vt, t, x, y;
    ht = c.hd + c.hfp + c.hs + c.hbp;
    vt = c.vd + c.vfp + c.vs + c.vbp;
    t  = e / c.div;
    x  = t % ht;
    y  = (t / ht) % vt;
    m.p   = (e != 0) && (e % c.div == 0);
    m.x   = 10'(x);
    m.y   = 10'(y);
    m.hs  = !((x >= c.hd + c.hfp) && (x < c.hd + c.hfp + c.hs));
    m.vs  = !((y >= c.vd + c.vfp) && (y < c.vd + c.vfp + c.vs));
    m.von = (x < c.hd) && (y < c.vd);
    m.ft  = m.p && (x == 0) && (y == 0);
    return m;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp(input int idx, input int unsigned e);
    exp_t m = model(idx, e);
    chk($sformatf("p_tick[%0d] e=%0d", idx, e), 32'(p[idx]), 32'(m.p));
    chk($sformatf("pixel_x[%0d] e=%0d", idx, e), 32'(px[idx]), 32'(m.x));
    chk($sformatf("pixel_y[%0d] e=%0d", idx, e), 32'(py[idx]), 32'(m.y));
    chk($sformatf("hsync[%0d] e=%0d", idx, e), 32'(hs[idx]), 32'(m.hs));
    chk($sformatf("vsync[%0d] e=%0d", idx, e), 32'(vs[idx]), 32'(m.vs));
    chk($sformatf("video_on[%0d] e=%0d", idx, e), 32'(von[idx]), 32'(m.von));
`ifdef VGA_FRAME_TICK_EN
    chk($sformatf("frame_tick[%0d] e=%0d", idx, e), 32'(ft[idx]), 32'(m.ft));
`endif
  endtask

  int unsigned e0 = 0, e1 = 0;
  logic        rs0, rs1;

  always @(posedge clk) begin
    rs0 = rst[0];
    #1;
    if (rs0) e0 = 0; else e0++;
    cmp(0, e0);
  end

  always @(posedge clk) begin
    rs1 = rst[1];
    #1;
    if (rs1) e1 = 0; else e1++;
    cmp(1, e1);
  end

  task automatic chk_reset(input int idx, input string nm);
    chk({nm, " x"}, 32'(px[idx]), 32'd0);
    chk({nm, " y"}, 32'(py[idx]), 32'd0);
    chk({nm, " hsync"}, 32'(hs[idx]), 32'd1);
    chk({nm, " vsync"}, 32'(vs[idx]), 32'd1);
    chk({nm, " video_on"}, 32'(von[idx]), 32'd1);
    chk({nm, " p_tick"}, 32'(p[idx]), 32'd0);
    chk({nm, " frame_tick"}, 32'(ft[idx]), 32'd0);
  endtask

  task automatic edges_to_tick(input int idx, input int budget, output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!p[idx] && n < budget);
  endtask

  task automatic wait_xy(input int idx, input int x, input int y, input int budget,
                         input string nm);
    int n = 0;
    while (!(px[idx] == 10'(x) && py[idx] == 10'(y))) begin
      @(posedge clk); #1;
      n++;
      if (n > budget) begin
        chk({nm, " timeout"}, 32'd0, 32'd1);
        return;
      end
    end
  endtask

  // Full-size instance: reset, divider, hsync edges, line wrap, mid-frame reset.
  initial begin
    int n;
    done[0] = 1'b0;
    rst[0]  = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk_reset(0, "f_reset");
    @(negedge clk) rst[0] = 1'b0;
    edges_to_tick(0, 20, n);
    chk("f_first_tick_edge", 32'(n), 32'd4);
    chk("f_first_tick_x", 32'(px[0]), 32'd1);
    edges_to_tick(0, 20, n);
    chk("f_tick_period", 32'(n), 32'd4);
    wait_xy(0, 639, 0, 4000, "f_x639");
    chk("f_von_639", 32'(von[0]), 32'd1);
    wait_xy(0, 640, 0, 20, "f_x640");
    chk("f_von_640", 32'(von[0]), 32'd0);
    wait_xy(0, 655, 0, 100, "f_x655");
    chk("f_hs_655", 32'(hs[0]), 32'd1);
    wait_xy(0, 656, 0, 20, "f_x656");
    chk("f_hs_656", 32'(hs[0]), 32'd0);
    wait_xy(0, 751, 0, 400, "f_x751");
    chk("f_hs_751", 32'(hs[0]), 32'd0);
    wait_xy(0, 752, 0, 20, "f_x752");
    chk("f_hs_752", 32'(hs[0]), 32'd1);
    wait_xy(0, 799, 5, 20000, "f_x799_y5");
    edges_to_tick(0, 20, n);
    chk("f_wrap_x", 32'(px[0]), 32'd0);
    chk("f_wrap_y", 32'(py[0]), 32'd6);
    wait_xy(0, 300, 6, 2000, "f_x300_y6");
    @(negedge clk) rst[0] = 1'b1;
    @(posedge clk); #1 chk_reset(0, "f_mid_reset");
    @(negedge clk) rst[0] = 1'b0;
    edges_to_tick(0, 20, n);
    chk("f_resume_tick_edge", 32'(n), 32'd4);
    chk("f_resume_x", 32'(px[0]), 32'd1);
    chk("f_resume_y", 32'(py[0]), 32'd0);
    done[0] = 1'b1;
  end

  // Shrunk instance (25x17, div 2): frame wrap, vsync window, frame_tick, reset.
  initial begin
    int n, cnt;
    done[1] = 1'b0;
    rst[1]  = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk_reset(1, "s_reset");
    @(negedge clk) rst[1] = 1'b0;
    edges_to_tick(1, 20, n);
    chk("s_first_tick_edge", 32'(n), 32'd2);
    wait_xy(1, 24, 16, 2000, "s_x24_y16");
    edges_to_tick(1, 20, n);
    chk("s_frame_wrap_x", 32'(px[1]), 32'd0);
    chk("s_frame_wrap_y", 32'(py[1]), 32'd0);
`ifdef VGA_FRAME_TICK_EN
    chk("s_frame_tick_on_wrap", 32'(ft[1]), 32'd1);
`endif
    cnt = 0;
    repeat (850) begin
      @(posedge clk); #1;
      if (ft[1]) cnt++;
    end
`ifdef VGA_FRAME_TICK_EN
    chk("s_frame_tick_count", 32'(cnt), 32'd1);
`else
    chk("s_frame_tick_count", 32'(cnt), 32'd0);
`endif
    wait_xy(1, 0, 11, 2000, "s_y11");
    chk("s_vs_y11", 32'(vs[1]), 32'd1);
    wait_xy(1, 0, 12, 200, "s_y12");
    chk("s_vs_y12", 32'(vs[1]), 32'd0);
    wait_xy(1, 0, 13, 200, "s_y13");
    chk("s_vs_y13", 32'(vs[1]), 32'd0);
    wait_xy(1, 0, 14, 200, "s_y14");
    chk("s_vs_y14", 32'(vs[1]), 32'd1);
    wait_xy(1, 10, 5, 2000, "s_x10_y5");
    @(negedge clk) rst[1] = 1'b1;
    @(posedge clk); #1 chk_reset(1, "s_mid_reset");
    @(negedge clk) rst[1] = 1'b0;
    edges_to_tick(1, 20, n);
    chk("s_resume_tick_edge", 32'(n), 32'd2);
    done[1] = 1'b1;
  end

  initial begin
    fork
      wait (done[0] === 1'b1 && done[1] === 1'b1);
      repeat (60000) @(posedge clk);
    join_any
    if (!(done[0] === 1'b1 && done[1] === 1'b1)) chk("overall_timeout", 32'd0, 32'd1);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
